// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundle of the producer handshake and the async_fifo write-port signals
//   around fifo_wr_arbiter.
//
//   req_valid  per-requester data valid
//   req_data   packed data, requester i at [i*DATA_SIZE +: DATA_SIZE]
//   req_ready  per-requester accept, at most one bit high
//   w_full     async_fifo full flag
//   w_data     data word to async_fifo
//   w_inc      write strobe to async_fifo
//
//   slave  : the arbiter's view (requests and w_full in, accept/write out)
//   master : the view of whatever drives the requests and models the FIFO
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int DATA_SIZE = 8,
  parameter int NUM_REQ   = 4
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         w_full;
  logic [DATA_SIZE-1:0]         w_data;
  logic                         w_inc;

  modport slave (
    input  req_valid, req_data, w_full,
    output req_ready, w_data, w_inc
  );

  modport master (
    output req_valid, req_data, w_full,
    input  req_ready, w_data, w_inc
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the single async_fifo write port among NUM_REQ producers in the
//   w_clk domain. Round-robin arbitration with bursts of at most BURST_LEN
//   beats per grant; each producer uses a valid/ready handshake and the
//   granted word goes straight onto w_data/w_inc in the same cycle.
//
//   w_clk     write-domain clock
//   w_rst     synchronous active-high reset
//   bus       fifo_wr_arbiter_if.slave (req_valid/req_data/req_ready,
//             w_full/w_data/w_inc)
//   grant_id  current or last granted requester
//   busy      high while a grant is active
//   wr_count  accepted-write counter, wraps silently
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter  int DATA_SIZE = 8,
  parameter  int NUM_REQ   = 4,
  parameter  int BURST_LEN = 4,
  localparam int IW        = $clog2(NUM_REQ)
) (
  input  logic                   w_clk,
  input  logic                   w_rst,
  fifo_wr_arbiter_if.slave       bus,
  output logic [IW-1:0]          grant_id,
  output logic                   busy,
  output logic [15:0]            wr_count
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] rr_ptr, rr_nxt, grant_nxt;
  logic [4:0]    beat_cnt, beat_nxt;
  logic [15:0]   count_nxt;

  logic [IW-1:0] g_plus1, search_start, win_id;
  logic          win_found, valid_g, xfer, last_beat, release_g;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] id);
    if (int'(id) == NUM_REQ - 1) return '0;
    return id + IW'(1);
  endfunction

  // Handshake terms of the current grant. A stalled beat (w_full) is not a
  // transfer and cannot release, so bursts survive arbitrarily long stalls.
  always_comb begin
    valid_g   = bus.req_valid[grant_id];
    xfer      = (state == GRANT) && valid_g && !bus.w_full;
    last_beat = (beat_cnt == 5'(BURST_LEN - 1));
    release_g = (state == GRANT) && (!valid_g || (xfer && last_beat));
    g_plus1   = wrap_inc(grant_id);
  end

  // Circular priority search. From IDLE it starts at the rr pointer; on a
  // release it starts just after the outgoing requester, which therefore
  // comes last. Scanning offsets from the far end lets the nearest valid
  // requester overwrite any farther one.
  always_comb begin
    logic [IW-1:0] idx;
    search_start = (state == IDLE) ? rr_ptr : g_plus1;
    win_found    = 1'b0;
    win_id       = search_start;
    idx          = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IW'((int'(search_start) + i) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // State register plus the grant bookkeeping that moves with it.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      wr_count <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= beat_nxt;
      wr_count <= count_nxt;
    end
  end

  // Next-state logic. A release re-arbitrates in the same edge so that a
  // waiting requester takes over without an idle bubble; grant_id keeps its
  // last value when nobody is waiting.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    rr_nxt    = rr_ptr;
    beat_nxt  = beat_cnt;
    count_nxt = wr_count;
    if (xfer) begin
      beat_nxt  = beat_cnt + 5'd1;
      count_nxt = wr_count + 16'd1;
    end
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = GRANT;
          grant_nxt = win_id;
          beat_nxt  = '0;
        end
      end
      GRANT: begin
        if (release_g) begin
          rr_nxt   = g_plus1;
          beat_nxt = '0;
          if (win_found) grant_nxt = win_id;
          else           state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. Everything is gated off while w_rst is high so that the reset
  // cycle can never push a word into the FIFO.
  always_comb begin
    bus.req_ready = '0;
    bus.w_inc     = 1'b0;
    bus.w_data    = '0;
    busy          = 1'b0;
    if (!w_rst && state == GRANT) begin
      busy                    = 1'b1;
      bus.req_ready[grant_id] = !bus.w_full;
      bus.w_inc               = valid_g && !bus.w_full;
      bus.w_data              = bus.req_data[grant_id*DATA_SIZE +: DATA_SIZE];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, BURST_LEN=4).
//   Producers are per-requester word queues obeying the valid/ready rule;
//   every word is also entered in a scoreboard in the order the arbiter is
//   expected to write it, and each w_inc pops and compares one entry.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
  localparam int DATA_SIZE = 8;
  localparam int NUM_REQ   = 4;
  localparam int BURST_LEN = 4;

  logic        w_clk = 1'b0;
  logic        w_rst;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] wr_count;

  fifo_wr_arbiter_if #(.DATA_SIZE(DATA_SIZE), .NUM_REQ(NUM_REQ)) bus_if ();

  fifo_wr_arbiter #(
    .DATA_SIZE(DATA_SIZE),
    .NUM_REQ  (NUM_REQ),
    .BURST_LEN(BURST_LEN)
  ) dut (
    .w_clk   (w_clk),
    .w_rst   (w_rst),
    .bus     (bus_if),
    .grant_id(grant_id),
    .busy    (busy),
    .wr_count(wr_count)
  );

  always #5 w_clk = ~w_clk;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t               sb[$];
  logic [7:0]         prod_q[NUM_REQ][$];
  logic [NUM_REQ-1:0] xfer_seen;
  int                 n_checks;
  int                 n_fails;
  int                 exp_total;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Queue n words starting at 'first' on requester id.
  task automatic applyStimulus(input int id, input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) prod_q[id].push_back(first + 8'(k));
  endtask

  // Record n words of requester id as the next expected FIFO writes.
  task automatic expectWrite(input int id, input logic [7:0] first, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.id   = 2'(id);
      e.data = first + 8'(k);
      sb.push_back(e);
    end
  endtask

  // Advance to just after the monitor sample of the next cycle.
  task automatic step();
    @(negedge w_clk);
    #2;
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int i = 0; i < NUM_REQ; i++) s += prod_q[i].size();
    return s;
  endfunction

  task automatic waitInc(input int budget);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!bus_if.w_inc && k < budget);
    checkOutput("inc_seen", 32'(bus_if.w_inc), 32'd1);
  endtask

  task automatic waitDrain(input int budget);
    int k;
    k = 0;
    while ((busy || sb.size() != 0 || pending() != 0) && k < budget) begin
      step();
      k++;
    end
    checkOutput("drain_in_time", 32'(k < budget), 32'd1);
  endtask

  // Producer model: drop the word accepted at the last edge, then present
  // the head of each queue, holding it until it is taken.
  initial begin
    logic [NUM_REQ-1:0]           v;
    logic [NUM_REQ*DATA_SIZE-1:0] d;
    bus_if.req_valid = '0;
    bus_if.req_data  = '0;
    forever begin
      @(negedge w_clk);
      v = '0;
      d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer_seen[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
        if (prod_q[i].size() > 0) begin
          v[i] = 1'b1;
          d[i*DATA_SIZE +: DATA_SIZE] = prod_q[i][0];
        end
      end
      bus_if.req_valid = v;
      bus_if.req_data  = d;
    end
  end

  // Monitor: samples the stable pre-edge values, checks the handshake
  // invariants and pops the scoreboard on every FIFO write.
  initial begin
    exp_t e;
    xfer_seen = '0;
    forever begin
      @(negedge w_clk);
      #1;
      xfer_seen = bus_if.req_valid & bus_if.req_ready;
      checkOutput("ready_onehot", 32'($onehot0(bus_if.req_ready)), 32'd1);
      checkOutput("inc_while_full", 32'(bus_if.w_inc & bus_if.w_full), 32'd0);
      if (bus_if.w_inc) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          checkOutput("w_data", 32'(bus_if.w_data), 32'(e.data));
          checkOutput("write_id", 32'(grant_id), 32'(e.id));
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence
  initial begin
    n_checks      = 0;
    n_fails       = 0;
    exp_total     = 0;
    w_rst         = 1'b1;
    bus_if.w_full = 1'b0;

    // Reset state
    repeat (2) step();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_inc", 32'(bus_if.w_inc), 32'd0);
    checkOutput("rst_ready", 32'(bus_if.req_ready), 32'd0);
    checkOutput("rst_wdata", 32'(bus_if.w_data), 32'd0);
    @(negedge w_clk);
    w_rst = 1'b0;
    #2;
    checkOutput("rst_grant", 32'(grant_id), 32'd0);
    checkOutput("rst_count", 32'(wr_count), 32'd0);

    // Single stream with re-grant at the burst limit
    $display("[TB] single stream");
    applyStimulus(0, 8'h10, 6);
    expectWrite(0, 8'h10, 6);
    step();
    checkOutput("t1_arb_latency", 32'(busy), 32'd0);
    checkOutput("t1_no_inc_yet", 32'(bus_if.w_inc), 32'd0);
    step();
    checkOutput("t1_grant", 32'(grant_id), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_inc", 32'(bus_if.w_inc), 32'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      checkOutput("t1_inc_run", 32'(bus_if.w_inc), 32'd1);
    end
    step();
    checkOutput("t1_inc_end", 32'(bus_if.w_inc), 32'd0);
    exp_total += 6;
    checkOutput("t1_count", 32'(wr_count), 32'(exp_total));
    waitDrain(20);

    // Round-robin between requesters 1 and 3
    $display("[TB] round robin");
    applyStimulus(1, 8'h20, 8);
    applyStimulus(3, 8'h30, 8);
    expectWrite(1, 8'h20, 4);
    expectWrite(3, 8'h30, 4);
    expectWrite(1, 8'h24, 4);
    expectWrite(3, 8'h34, 4);
    waitInc(5);
    checkOutput("t2_first_grant", 32'(grant_id), 32'd1);
    for (int k = 0; k < 15; k++) begin
      step();
      checkOutput("t2_no_bubble", 32'(bus_if.w_inc), 32'd1);
    end
    waitDrain(20);
    exp_total += 16;
    checkOutput("t2_count", 32'(wr_count), 32'(exp_total));

    // Full stall at beat 2
    $display("[TB] full stall");
    applyStimulus(0, 8'h40, 4);
    expectWrite(0, 8'h40, 4);
    waitInc(5);
    step();
    for (int s = 0; s < 5; s++) begin
      @(negedge w_clk);
      bus_if.w_full = 1'b1;
      #2;
      checkOutput("t3_stall_inc", 32'(bus_if.w_inc), 32'd0);
      checkOutput("t3_stall_ready", 32'(bus_if.req_ready), 32'd0);
      checkOutput("t3_stall_grant", 32'(grant_id), 32'd0);
      checkOutput("t3_stall_count", 32'(wr_count), 32'(exp_total + 2));
      checkOutput("t3_stall_busy", 32'(busy), 32'd1);
    end
    @(negedge w_clk);
    bus_if.w_full = 1'b0;
    #2;
    checkOutput("t3_resume_inc", 32'(bus_if.w_inc), 32'd1);
    checkOutput("t3_resume_data", 32'(bus_if.w_data), 32'h42);
    step();
    checkOutput("t3_last_data", 32'(bus_if.w_data), 32'h43);
    step();
    checkOutput("t3_done_inc", 32'(bus_if.w_inc), 32'd0);
    exp_total += 4;
    checkOutput("t3_count", 32'(wr_count), 32'(exp_total));
    waitDrain(20);

    // Early release of requester 2, search wraps to requester 0
    $display("[TB] early release");
    applyStimulus(2, 8'h50, 2);
    applyStimulus(0, 8'h60, 3);
    expectWrite(2, 8'h50, 2);
    expectWrite(0, 8'h60, 3);
    waitInc(5);
    checkOutput("t4_first_grant", 32'(grant_id), 32'd2);
    step();
    step();
    checkOutput("t4_drop_inc", 32'(bus_if.w_inc), 32'd0);
    checkOutput("t4_drop_grant", 32'(grant_id), 32'd2);
    checkOutput("t4_count", 32'(wr_count), 32'(exp_total + 2));
    step();
    checkOutput("t4_next_grant", 32'(grant_id), 32'd0);
    checkOutput("t4_next_inc", 32'(bus_if.w_inc), 32'd1);
    waitDrain(20);

    // Reset at beat 3, then all requesters valid
    $display("[TB] reset mid-burst");
    applyStimulus(1, 8'h70, 6);
    expectWrite(1, 8'h70, 3);
    waitInc(5);
    step();
    step();
    @(negedge w_clk);
    w_rst = 1'b1;
    #2;
    checkOutput("t5_rst_inc", 32'(bus_if.w_inc), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_ready", 32'(bus_if.req_ready), 32'd0);
    checkOutput("t5_rst_wdata", 32'(bus_if.w_data), 32'd0);
    applyStimulus(0, 8'h80, 2);
    applyStimulus(2, 8'h90, 2);
    applyStimulus(3, 8'hA0, 2);
    expectWrite(0, 8'h80, 2);
    expectWrite(1, 8'h73, 3);
    expectWrite(2, 8'h90, 2);
    expectWrite(3, 8'hA0, 2);
    @(negedge w_clk);
    w_rst = 1'b0;
    #2;
    checkOutput("t5_idle_busy", 32'(busy), 32'd0);
    checkOutput("t5_idle_count", 32'(wr_count), 32'd0);
    checkOutput("t5_idle_grant", 32'(grant_id), 32'd0);
    step();
    checkOutput("t5_first_grant", 32'(grant_id), 32'd0);
    checkOutput("t5_first_inc", 32'(bus_if.w_inc), 32'd1);
    waitDrain(40);
    exp_total = 9;
    checkOutput("t5_count", 32'(wr_count), 32'(exp_total));

    // Counter wrap
    $display("[TB] counter wrap");
    applyStimulus(3, 8'h00, 65535 - exp_total);
    expectWrite(3, 8'h00, 65535 - exp_total);
    waitDrain(70000);
    checkOutput("t6_count_max", 32'(wr_count), 32'hFFFF);
    applyStimulus(0, 8'hB0, 1);
    applyStimulus(2, 8'hC0, 1);
    expectWrite(0, 8'hB0, 1);
    expectWrite(2, 8'hC0, 1);
    waitInc(5);
    checkOutput("t6_grant_a", 32'(grant_id), 32'd0);
    step();
    checkOutput("t6_count_wrap", 32'(wr_count), 32'd0);
    step();
    checkOutput("t6_grant_b", 32'(grant_id), 32'd2);
    checkOutput("t6_inc_b", 32'(bus_if.w_inc), 32'd1);
    waitDrain(20);
    checkOutput("t6_count_after", 32'(wr_count), 32'd1);

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side scheduler for async_fifo. Shares the single FIFO write port (w_data/w_inc/w_full) among NUM_REQ producers in the w_clk domain.
- Arbitration is round-robin with bounded bursts; each requester uses a valid/ready handshake.
- Drives async_fifo w_data and w_inc directly and honours w_full.
- Keeps a running count of accepted writes for debug/coverage.

Parameters:
DATA_SIZE, 8, width of one data word; matches async_fifo DATA_SIZE.
NUM_REQ, 4, number of requesters (2..8).
BURST_LEN, 4, maximum beats per grant before forced rotation (1..16).

Ports:
w_clk  input  1  write-domain clock, shared with async_fifo write side.
w_rst  input  1  reset, synchronous to w_clk, active-high.
req_valid  input  NUM_REQ  per-requester data valid.
req_data  input  NUM_REQ*DATA_SIZE  packed data; requester i occupies bits [i*DATA_SIZE +: DATA_SIZE].
req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
w_full  input  1  async_fifo full flag.
w_data  output  DATA_SIZE  to async_fifo w_data.
w_inc  output  1  to async_fifo w_inc.
grant_id  output  $clog2(NUM_REQ)  current/last granted requester.
busy  output  1  high while in GRANT state.
wr_count  output  16  accepted-write counter, wraps 16'hFFFF->0.

Behaviour:
- Reset (w_rst=1 at a w_clk edge):
  - state=IDLE, grant_id=0, rr pointer=0 (requester 0 highest priority), beat_cnt=0, wr_count=0.
  - While w_rst is high, w_inc=0, req_ready=0, w_data=0, busy=0, combinationally gated.
  - Reset mid-burst aborts the burst; no write occurs in the reset cycle.
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid at the edge: winner = first valid at or after rr pointer, circular. grant_id<=winner, beat_cnt<=0, next state GRANT. One cycle of arbitration latency.
  - Otherwise stay in IDLE.
- GRANT, with g = grant_id:
  - req_ready[g] = ~w_full; all other bits are 0.
  - w_inc = req_valid[g] & ~w_full.
  - w_data = req_data[g] in GRANT; 0 in IDLE.
  - Transfer occurs when req_valid[g] & req_ready[g]. The same-cycle w_inc means zero added latency into the FIFO.
  - On each transfer: beat_cnt++, wr_count++.
- Release at the edge when either:
  - a transfer occurs with beat_cnt==BURST_LEN-1, or
  - req_valid[g]==0.
- On release:
  - rr pointer<=g+1 (mod NUM_REQ).
  - Re-arbitrate in the same edge, starting from g+1, among the req_valid values sampled at that edge. Requester g is lowest priority and is eligible only if it still asserts valid after a burst-limit release.
  - Winner found: stay in GRANT with new grant_id and beat_cnt=0, no bubble cycle.
  - No winner: go to IDLE; grant_id holds its last value.
- w_full stall:
  - Grant is held, beat_cnt and wr_count are frozen, w_inc=0.
  - A stall never causes a release, even if it is indefinite.
- Requester rule: once req_valid is asserted, it must stay asserted with stable req_data until the transfer. A drop while granted is treated as end-of-stream and releases the grant.
- w_full is sampled combinationally every cycle. The arbiter never asserts w_inc while w_full=1, so it cannot overflow the FIFO.
- Other behaviour:
  - req_valid of non-granted requesters has no effect until the next arbitration.
  - wr_count wraps silently.
  - busy = (state==GRANT).

Test Plan:
1. Single stream: with NUM_REQ=4 and BURST_LEN=4, req 0 streams 6 words 0x10..0x15.
   - Required: grant_id=0 one cycle after valid; w_inc high for 6 consecutive cycles; w_data 0x10..0x15 in order.
   - The 4th beat causes a release and immediate re-grant of req 0 with no bubble; wr_count=6.
2. Round-robin: reqs 1 and 3 valid continuously, w_full=0.
   - Required: grants alternate 1,3,1,3 with 4 beats each; no idle cycles between bursts; req_ready is one-hot throughout.
3. Full stall: hold w_full=1 for 5 cycles mid-burst at beat 2.
   - Required: w_inc=0 and req_ready=0 during the stall; beat_cnt and wr_count frozen; grant_id unchanged.
   - After w_full drops, the burst resumes at beat 2 and completes with 4 total beats; no word is lost or duplicated.
4. Early release: req 2 drops valid after 2 beats while req 0 is valid.
   - Required: at the next edge grant_id=0 (search from 3 wraps to 0); wr_count is +2 for req 2.
5. Reset mid-burst: assert w_rst for 1 cycle at beat 3.
   - Required: w_inc=0 in that cycle; next cycle state=IDLE, wr_count=0, grant_id=0, busy=0.
   - With all requesters then valid, req 0 wins first.
6. Counter wrap: preload via 65,536 accepted writes.
   - Required: wr_count goes 16'hFFFF->16'h0000 with no effect on arbitration.
